gameover_reader: RTL and testbench
==================================

# gameover_reader

Pixel-side consumer of the game-over banner's sprite address stream. Each cycle it takes the object hit flag and sprite ROM address from the banner locator, issues a read to the synchronous banner ROM, maps the returned 4-bit palette index through a writable 16-entry palette, and presents pipeline-aligned RGB and opacity to the VGA colour mux. An optional frame-counted blink gates the banner on and off.

## Interface
Parameters:
- ADDR_W, 15, sprite ROM address width
- SPRITE_WORDS, 6293, valid ROM words (203 x 31); addresses at or above this are out of range
- TRANSPARENT_IDX, 0, palette index treated as see-through
- BLINK_HALF, 16, frames per blink phase (only with GAMEOVER_BLINK_EN)

Ports:
- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high
- pixel_valid  in  1  display-enable for the current pixel
- frame_start  in  1  one-cycle pulse at the first pixel of each frame
- is_obj  in  1  current pixel lies inside the banner
- Obj_address  in  ADDR_W  sprite ROM address for the current pixel
- rom_rd  out  1  ROM read strobe
- rom_addr  out  ADDR_W  ROM read address
- rom_data  in  4  palette index; valid exactly 1 cycle after rom_rd
- pal_we  in  1  palette write enable
- pal_idx  in  4  palette entry to write
- pal_rgb  in  24  {R,G,B} write data
- pix_valid  out  1  output pixel qualifier
- pix_opaque  out  1  banner covers this pixel
- Red, Green, Blue  out  8 each  banner colour; 0 when not opaque

## Operation
- Stage 0 (issue): rom_rd = pixel_valid & is_obj & (Obj_address < SPRITE_WORDS) & show; rom_addr registered from Obj_address. Registered hit flag s0_hit and s0_valid = pixel_valid.
- Stage 1 (return): capture rom_data into s1_idx when s0_hit; propagate valid/hit.
- Stage 2 (colour): pix_opaque = s1_valid & s1_hit & (s1_idx != TRANSPARENT_IDX); RGB = palette[s1_idx] if opaque else 0; pix_valid = s1_valid.
- Out-of-range address: no ROM read, pixel emitted transparent with pix_valid preserved.
- pixel_valid low: bubble propagates; pix_valid low, pix_opaque low, RGB 0.
- Palette: 16 x 24-bit registers, written on rising edge when pal_we. Stage-2 lookup in the same cycle as a write to the same entry returns the old value; the new value is visible from the next cycle.
- show is constant 1 without blink; see Configuration.

## Timing
- Latency: is_obj/Obj_address at edge N -> rom_rd/rom_addr valid after edge N; pix_* valid after edge N+2 (3 register stages total incl. ROM).
- Throughput: one pixel per cycle, no stalls, no backpressure.
- Reset (sync): on the edge with Reset high, all pipeline valids/hits clear, rom_rd=0, rom_addr=0, pix_valid=0, pix_opaque=0, RGB=0, palette entries all 0, blink counter 0, show=1. Reset mid-frame discards in-flight pixels; first output after release appears 3 cycles after the first post-reset pixel.
- frame_start and pixel_valid may be high together; blink update and the pixel issue occur in the same cycle, new show value applies from the following cycle.

## Configuration
- GAMEOVER_BLINK_EN defined: frame counter (width clog2(BLINK_HALF)) increments on frame_start, wraps at BLINK_HALF-1 to 0 and toggles show. show=1 for frames 0..BLINK_HALF-1 after reset, 0 for the next BLINK_HALF, repeating. While show=0, rom_rd is held 0 and pixels emit transparent.
- Not defined: no counter, show tied 1, frame_start ignored.

## Test plan
- Reset, palette[5]=24'hFF0000, drive pixel_valid=1, is_obj=1, Obj_address=100, ROM model returns 5 -> rom_rd=1, rom_addr=100 next cycle; pix_opaque=1, RGB=FF/00/00 two cycles later.
- ROM returns 0 for an in-banner pixel -> pix_valid=1, pix_opaque=0, RGB=0.
- Obj_address=6293 with is_obj=1 -> rom_rd stays 0, pixel transparent; Obj_address=6292 -> rom_rd=1.
- Continuous stream of 10 pixels with pixel_valid low on the 4th -> outputs emitted back-to-back, bubble exactly at output 4, 3-cycle alignment held.
- pal_we to entry 5 with new value in the same cycle stage 2 looks up index 5 -> old colour that cycle, new colour next pixel using index 5.
- Reset asserted mid-stream for 1 cycle -> all outputs 0 on next edge, palette cleared; with GAMEOVER_BLINK_EN, 16 frame_start pulses -> show drops, rom_rd held 0; 16 more -> rendering resumes.

Source files
------------

// File: rtl/gameover_reader.sv
// gameover_reader: renders the game-over banner for the VGA colour mux.
// Takes the banner locator's hit flag and sprite address and reads the
// synchronous banner ROM. It maps the returned 4-bit palette index through a
// writable 16-entry palette and presents RGB and opacity three register stages
// after the request.
// Optional feature: define GAMEOVER_BLINK_EN to gate the banner on and off
// every BLINK_HALF frames, counted on frame_start. If it is not defined, the
// banner is always shown and frame_start is ignored.
module gameover_reader #(
  parameter int ADDR_W          = 15,
  parameter int SPRITE_WORDS    = 6293,
  parameter int TRANSPARENT_IDX = 0,
  parameter int BLINK_HALF      = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pixel_valid,
  input  logic              frame_start,
  input  logic              is_obj,
  input  logic [ADDR_W-1:0] Obj_address,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  input  logic              pal_we,
  input  logic [3:0]        pal_idx,
  input  logic [23:0]       pal_rgb,
  output logic              pix_valid,
  output logic              pix_opaque,
  output logic [7:0]        Red,
  output logic [7:0]        Green,
  output logic [7:0]        Blue
);

  // One extra bit so that a sprite size equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(SPRITE_WORDS);
  localparam logic [3:0]      TRANSP     = 4'(TRANSPARENT_IDX);

  logic        show;
  logic        in_range;
  logic        issue;

  logic        vld_p0, hit_p0;
  logic        vld_p1, hit_p1;
  logic        vld_p2, hit_p2;
  logic [3:0]  idx_p2;

  logic [23:0] palette [16];
  logic [23:0] rgb_p2;
  logic        opaque_p2;

`ifdef GAMEOVER_BLINK_EN
  localparam int CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

  logic [CNT_W-1:0] frame_cnt;
  logic             show_q;

  // Count frames and flip visibility every BLINK_HALF frames. The new value
  // takes effect on the cycle after the frame_start pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_cnt <= '0;
      show_q    <= 1'b1;
    end else if (frame_start) begin
      if (frame_cnt == CNT_LAST) begin
        frame_cnt <= '0;
        show_q    <= ~show_q;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign show = show_q;
`else
  logic unused_frame_start;

  assign unused_frame_start = frame_start;
  assign show               = 1'b1;
`endif

  // The ROM is only read for a displayed pixel inside the banner with an in-range address.
  always_comb begin
    in_range = ({1'b0, Obj_address} < ADDR_LIMIT);
    issue    = pixel_valid & is_obj & in_range & show;
  end

  // ---- stage 0: issue the ROM read ----
  // Register the read request and the pixel's valid and hit flags.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_p0   <= 1'b0;
      hit_p0   <= 1'b0;
      rom_addr <= '0;
    end else begin
      vld_p0   <= pixel_valid;
      hit_p0   <= issue;
      rom_addr <= Obj_address;
    end
  end

  // The read strobe is the registered hit: a miss or out-of-range pixel never touches the ROM.
  assign rom_rd = hit_p0;

  // ---- stage 1: ROM access in flight ----
  // Carry the control flags alongside the ROM's internal register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_p1 <= 1'b0;
      hit_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      hit_p1 <= hit_p0;
    end
  end

  // ---- stage 2: capture the returned palette index ----
  // Update control flags; the index is loaded only when a read was issued.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_p2 <= 1'b0;
      hit_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      hit_p2 <= hit_p1;
    end
  end

  // Palette index datapath register. Downstream logic qualifies it by hit_p2,
  // so it does not need a reset.
  always_ff @(posedge Clk) begin
    if (hit_p1) begin
      idx_p2 <= rom_data;
    end
  end

  // Palette registers. A lookup in the same cycle as a write sees the old
  // entry; the written value appears from the next cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) begin
        palette[i] <= '0;
      end
    end else if (pal_we) begin
      palette[pal_idx] <= pal_rgb;
    end
  end

  // Colour lookup: opacity needs a live hit whose index is not the see-through index.
  always_comb begin
    opaque_p2 = vld_p2 & hit_p2 & (idx_p2 != TRANSP);
    rgb_p2    = '0;
    if (opaque_p2) begin
      rgb_p2 = palette[idx_p2];
    end
  end

  assign pix_valid  = vld_p2;
  assign pix_opaque = opaque_p2;
  assign Red        = rgb_p2[23:16];
  assign Green      = rgb_p2[15:8];
  assign Blue       = rgb_p2[7:0];

endmodule

// File: tb/tb_gameover_reader.sv
// Testbench for gameover_reader: random and directed pixel streams are
// checked against a reference model through scoreboard queues.
// The blink expectations follow GAMEOVER_BLINK_EN in the same way as the design.
module tb_gameover_reader;

  localparam int SW = 6293;
  localparam int BH = 16;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        pixel_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic        is_obj = 1'b0;
  logic [14:0] Obj_address = '0;
  logic        rom_rd;
  logic [14:0] rom_addr;
  logic [3:0]  rom_data = '0;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_idx = '0;
  logic [23:0] pal_rgb = '0;
  logic        pix_valid, pix_opaque;
  logic [7:0]  Red, Green, Blue;

  gameover_reader dut (
    .Clk(Clk), .Reset(Reset), .pixel_valid(pixel_valid), .frame_start(frame_start),
    .is_obj(is_obj), .Obj_address(Obj_address), .rom_rd(rom_rd), .rom_addr(rom_addr),
    .rom_data(rom_data), .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb),
    .pix_valid(pix_valid), .pix_opaque(pix_opaque), .Red(Red), .Green(Green), .Blue(Blue)
  );

  always #5 Clk = ~Clk;

  typedef struct { int stamp; int epoch; bit opaque; logic [3:0] idx; } pix_t;
  typedef struct { int stamp; int epoch; bit rd; logic [14:0] addr; } rd_t;

  pix_t pq[$];
  rd_t  rq[$];
  pix_t p;
  rd_t  e;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int epoch   = 0;
  int fc      = 0;
  bit mon_en  = 1'b0;

  logic [3:0]  rom_mem [0:32767];
  logic [23:0] pal_model [16];
  logic [23:0] exp_rgb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Synchronous ROM model; unread cycles present junk so that stale data is noticed.
  always @(posedge Clk) rom_data <= rom_rd ? rom_mem[rom_addr] : 4'($urandom);

  always @(posedge Clk) cyc <= cyc + 1;
  always @(posedge Clk) if (Reset) epoch <= epoch + 1;

  // Reference palette: committed at the clock edge, then read by the checker afterwards.
  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) pal_model[i] <= '0;
    end else if (pal_we) begin
      pal_model[pal_idx] <= pal_rgb;
    end
  end

  // Monitor: compares DUT outputs against queued expectations on the falling edge.
  always @(negedge Clk) begin
    if (mon_en) begin
      while (pq.size() > 0 && pq[0].epoch != epoch) void'(pq.pop_front());
      while (rq.size() > 0 && rq[0].epoch != epoch) void'(rq.pop_front());
      if (rq.size() > 0 && rq[0].stamp == cyc) begin
        e = rq.pop_front();
        chk("rom_rd", {31'b0, rom_rd}, {31'b0, e.rd});
        chk("rom_addr", {17'b0, rom_addr}, {17'b0, e.addr});
      end
      if (pq.size() > 0 && pq[0].stamp == cyc) begin
        p = pq.pop_front();
        exp_rgb = p.opaque ? pal_model[p.idx] : 24'h0;
        chk("pix_valid", {31'b0, pix_valid}, 32'd1);
        chk("pix_opaque", {31'b0, pix_opaque}, {31'b0, p.opaque});
        chk("pix_rgb", {8'b0, Red, Green, Blue}, {8'b0, exp_rgb});
      end else begin
        chk("pix_valid_idle", {31'b0, pix_valid}, 32'd0);
        chk("pix_opaque_idle", {31'b0, pix_opaque}, 32'd0);
        chk("pix_rgb_idle", {8'b0, Red, Green, Blue}, 32'd0);
      end
    end
  end

  // Drive one cycle of inputs and queue what the block must produce for them.
  task automatic drive(input bit pv, input bit obj, input logic [14:0] addr, input bit fs,
                       input bit we, input logic [3:0] wi, input logic [23:0] wrgb);
    bit show_m, rd;
    Reset = 1'b0;
    pixel_valid = pv; is_obj = obj; Obj_address = addr; frame_start = fs;
    pal_we = we; pal_idx = wi; pal_rgb = wrgb;
`ifdef GAMEOVER_BLINK_EN
    show_m = ((fc / BH) % 2) == 0;
`else
    show_m = 1'b1;
`endif
    rd = pv && obj && (int'(addr) < SW) && show_m;
    rq.push_back('{stamp: cyc + 1, epoch: epoch, rd: rd, addr: addr});
    if (pv)
      pq.push_back('{stamp: cyc + 3, epoch: epoch, opaque: rd && (rom_mem[addr] != 4'd0),
                     idx: rom_mem[addr]});
    if (fs) fc++;
    @(posedge Clk); #1;
  endtask

  task automatic px(input logic [14:0] addr);
    drive(1'b1, 1'b1, addr, 1'b0, 1'b0, 4'd0, 24'd0);
  endtask

  task automatic do_reset(input bit check);
    Reset = 1'b1; pixel_valid = 1'b0; is_obj = 1'b0; Obj_address = '0;
    frame_start = 1'b0; pal_we = 1'b0;
    fc = 0;
    @(posedge Clk); #1;
    if (check) begin
      chk("rst_rom_rd", {31'b0, rom_rd}, 32'd0);
      chk("rst_rom_addr", {17'b0, rom_addr}, 32'd0);
      chk("rst_pix_valid", {31'b0, pix_valid}, 32'd0);
      chk("rst_pix_opaque", {31'b0, pix_opaque}, 32'd0);
      chk("rst_rgb", {8'b0, Red, Green, Blue}, 32'd0);
    end
    Reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32768; i++) rom_mem[i] = 4'($urandom_range(0, 15));
    rom_mem[100]  = 4'd5;
    rom_mem[200]  = 4'd0;
    rom_mem[6292] = 4'd5;
    rom_mem[6293] = 4'd5;

    @(posedge Clk); #1;
    do_reset(1'b0);
    do_reset(1'b1);
    mon_en = 1'b1;

    // Basic hit: palette entry 5 is red, ROM returns 5.
    drive(1'b0, 1'b0, 15'd0, 1'b0, 1'b1, 4'd5, 24'hFF0000);
    px(15'd100);
    // Transparent index inside the banner.
    px(15'd200);
    // Address boundary: first out-of-range, then the last valid word.
    px(15'd6293);
    px(15'd6292);
    // Ten-pixel stream with a bubble at the fourth pixel.
    for (int i = 0; i < 10; i++)
      drive(i != 3, 1'b1, 15'(300 + i), 1'b0, 1'b0, 4'd0, 24'd0);
    // Palette write that coincides with a stage-2 lookup of the same entry.
    px(15'd100); px(15'd100); px(15'd100);
    drive(1'b1, 1'b1, 15'd100, 1'b0, 1'b1, 4'd5, 24'h00FF00);
    px(15'd100); px(15'd100);

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      logic [14:0] a;
      a = (i % 17 == 0) ? 15'(6292 + (i % 2)) : 15'($urandom_range(0, 6400));
      drive($urandom % 8 != 0, $urandom % 4 != 0, a, $urandom % 40 == 0,
            $urandom % 10 == 0, 4'($urandom), 24'($urandom));
    end

    // Reset in the middle of the stream: pending pixels are dropped and the palette is cleared.
    px(15'd100); px(15'd100);
    do_reset(1'b1);
    px(15'd100); px(15'd100);
    drive(1'b0, 1'b0, 15'd0, 1'b0, 1'b1, 4'd5, 24'h123456);

    // Frame pulses: the banner blinks off after BH frames and returns after another BH.
    for (int f = 0; f < 2 * BH + 2; f++) begin
      drive(1'b1, 1'b1, 15'd100, 1'b1, 1'b0, 4'd0, 24'd0);
      px(15'($urandom_range(0, 6292)));
      px(15'd100);
    end

    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 4'd0, 24'd0);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("drain_pix_queue", pq.size(), 32'd0);
    chk("drain_rd_queue", rq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
